uart_tx_serializer: RTL and testbench

Transmit serializer for the 8250-compatible UART. It sits directly downstream of the Wishbone register block (`uart_8250`) and consumes THR writes plus the LCR/FCR fields that block decodes. It buffers bytes, then shifts them onto `txd_o` as asynchronous serial frames. It also returns the LSR transmit status bits to the register block.

---
 rtl/uart_tx_serializer.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit side of an 8250/16550-compatible UART. It accepts THR bytes from the
// register block, buffers them, and shifts each one out on txd_o as an
// asynchronous frame: start, 5..8 data bits LSB first, optional parity, and
// 1 / 1.5 / 2 stop bits. Every bit lasts 16 baud_tick_i pulses.
//
// Build option:
//   UART_TX_FIFO_EN defined   : FIFO_DEPTH-entry circular FIFO (16550 mode)
//   UART_TX_FIFO_EN undefined : single holding register (8250 mode); a write
//                               while full overwrites the held byte
//
// Ports:
//   CLK_I, RST_I       clock, asynchronous active-high reset
//   baud_tick_i        16x oversample enable, one cycle wide
//   wr_i, wr_data_i    THR write strobe and byte
//   fifo_clr_i         clears the buffer (wins over a same-cycle write)
//   lcr_wls_i          word length (00=5 .. 11=8)
//   lcr_stb_i          stop-bit select
//   lcr_pen_i          parity enable
//   lcr_eps_i          even parity select
//   lcr_sp_i           stick parity
//   lcr_bc_i           break control, forces txd_o low
//   txd_o              serial output, idle high
//   thre_o             buffer empty
//   temt_o             buffer empty and shifter idle
//   tx_level_o         bytes held in the buffer
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       baud_tick_i,
    input  logic       wr_i,
    input  logic [7:0] wr_data_i,
    input  logic       fifo_clr_i,
    input  logic [1:0] lcr_wls_i,
    input  logic       lcr_stb_i,
    input  logic       lcr_pen_i,
    input  logic       lcr_eps_i,
    input  logic       lcr_sp_i,
    input  logic       lcr_bc_i,
    output logic       txd_o,
    output logic       thre_o,
    output logic       temt_o,
    output logic [4:0] tx_level_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0] state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;          // index of the data bit on the line
    logic [2:0] nbits_q, nbits_d;      // word length minus one
    logic [7:0] shift_q, shift_d;
    logic       pen_q, pen_d;
    logic       par_q, par_d;
    logic [1:0] half_q, half_d;        // stop half-bits already completed
    logic [1:0] stop_last_q, stop_last_d;

    logic       buf_empty;
    logic [7:0] buf_data;
    logic       pop;
    logic       wr_ok;

    // A clear in the same cycle suppresses both the write and the load.
    assign pop   = (state_q == S_IDLE) && !buf_empty && !fifo_clr_i;
    assign wr_ok = wr_i && !fifo_clr_i;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full;
    logic          push;

    assign full = (count_q == (AW+1)'(FIFO_DEPTH));
    // When full, a simultaneous pop frees the slot being written.
    assign push = wr_ok && (!full || pop);

    always_ff @(posedge CLK_I) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (fifo_clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign buf_empty  = (count_q == '0);
    assign buf_data   = mem_q[rd_ptr_q];
    assign tx_level_o = 5'(count_q);
`else
    logic [7:0] hold_q;
    logic       full_q;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            hold_q <= 8'h00;
            full_q <= 1'b0;
        end else if (fifo_clr_i) begin
            full_q <= 1'b0;
        end else if (wr_ok) begin
            hold_q <= wr_data_i;
            full_q <= 1'b1;
        end else if (pop) begin
            full_q <= 1'b0;
        end
    end

    assign buf_empty  = !full_q;
    assign buf_data   = hold_q;
    assign tx_level_o = (FIFO_DEPTH > 0) ? {4'b0000, full_q} : 5'd0;
`endif

    logic [7:0] load_mask;
    logic       tick_end;
    logic       half_end;

    assign load_mask = 8'hFF >> (2'd3 - lcr_wls_i);
    assign tick_end  = baud_tick_i && (tick_q == 4'hF);
    assign half_end  = baud_tick_i && (tick_q[2:0] == 3'd7);

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        nbits_d     = nbits_q;
        shift_d     = shift_q;
        pen_d       = pen_q;
        par_d       = par_q;
        half_d      = half_q;
        stop_last_d = stop_last_q;

        if (pop) begin
            state_d = S_START;
            tick_d  = 4'h0;
            bit_d   = 3'd0;
            half_d  = 2'd0;
            shift_d = buf_data;
            nbits_d = {1'b1, lcr_wls_i};
            pen_d   = lcr_pen_i;
            if (lcr_sp_i) begin
                par_d = ~lcr_eps_i;
            end else if (lcr_eps_i) begin
                par_d = ^(buf_data & load_mask);
            end else begin
                par_d = ~^(buf_data & load_mask);
            end
            // Stop length in half-bits, minus one: 2, 3 or 4 half-bits.
            if (!lcr_stb_i) begin
                stop_last_d = 2'd1;
            end else if (lcr_wls_i == 2'b00) begin
                stop_last_d = 2'd2;
            end else begin
                stop_last_d = 2'd3;
            end
        end else if (state_q != S_IDLE && baud_tick_i) begin
            tick_d = tick_q + 1'b1;
            case (state_q)
                S_START: begin
                    if (tick_end) state_d = S_DATA;
                end
                S_DATA: begin
                    if (tick_end) begin
                        shift_d = shift_q >> 1;
                        if (bit_q == nbits_q) begin
                            state_d = pen_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick_end) state_d = S_STOP;
                end
                S_STOP: begin
                    if (half_end) begin
                        if (half_q == stop_last_q) begin
                            state_d = S_IDLE;
                        end else begin
                            half_d = half_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= S_IDLE;
            tick_q      <= 4'h0;
            bit_q       <= 3'd0;
            nbits_q     <= 3'd7;
            shift_q     <= 8'h00;
            pen_q       <= 1'b0;
            par_q       <= 1'b0;
            half_q      <= 2'd0;
            stop_last_q <= 2'd1;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            nbits_q     <= nbits_d;
            shift_q     <= shift_d;
            pen_q       <= pen_d;
            par_q       <= par_d;
            half_q      <= half_d;
            stop_last_q <= stop_last_d;
        end
    end

    logic line;

    always_comb begin
        case (state_q)
            S_START:  line = 1'b0;
            S_DATA:   line = shift_q[0];
            S_PARITY: line = par_q;
            default:  line = 1'b1;
        endcase
    end

    // Break overrides the line without disturbing the frame timing.
    assign txd_o  = line & ~lcr_bc_i;
    assign thre_o = buf_empty;
    assign temt_o = buf_empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       wr;
    logic [7:0] wr_data;
    logic       fifo_clr;
    logic [1:0] wls;
    logic       stb, pen, eps, sp, bc;
    logic       txd, thre, temt;
    logic [4:0] level;

    int errors = 0;
    int checks = 0;
    int pos    = 0;   // clocks since the current frame's load edge

    always #5 clk = ~clk;

    uart_tx_serializer #(.FIFO_DEPTH(16)) dut (
        .CLK_I       (clk),
        .RST_I       (rst),
        .baud_tick_i (baud_tick),
        .wr_i        (wr),
        .wr_data_i   (wr_data),
        .fifo_clr_i  (fifo_clr),
        .lcr_wls_i   (wls),
        .lcr_stb_i   (stb),
        .lcr_pen_i   (pen),
        .lcr_eps_i   (eps),
        .lcr_sp_i    (sp),
        .lcr_bc_i    (bc),
        .txd_o       (txd),
        .thre_o      (thre),
        .temt_o      (temt),
        .tx_level_o  (level)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, landing 1 ns after the active edge.
    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pos++;
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr      = 1'b1;
        wr_data = d;
        adv(1);
        wr      = 1'b0;
    endtask

    task automatic set_lcr(input logic [1:0] w, input logic s, input logic p,
                           input logic e, input logic k);
        wls = w; stb = s; pen = p; eps = e; sp = k;
    endtask

    // Write a byte into an idle, empty serializer and stop just after the load edge.
    task automatic launch(input logic [7:0] d);
        write_byte(d);
        adv(1);
        pos = 0;
    endtask

    // exp holds the expected line level per bit-time (start first); bits k0..nb-1
    // are sampled mid-bit, then the stop length is checked through temt_o.
    task automatic check_frame(input string tag, input logic [15:0] exp, input int k0,
                               input int nb, input int stop_ticks, input logic exp_temt);
        logic [15:0] e;
        e = exp;
        for (int k = k0; k < nb; k++) begin
            adv(16 * k + 8 - pos);
            chk($sformatf("%s bit%0d", tag, k), 16'(txd), 16'(e[k]));
        end
        adv(16 * nb + stop_ticks - 1 - pos);
        chk($sformatf("%s stop_last_txd", tag), 16'(txd), 16'd1);
        chk($sformatf("%s stop_last_temt", tag), 16'(temt), 16'd0);
        adv(1);
        chk($sformatf("%s end_temt", tag), 16'(temt), 16'(exp_temt));
        chk($sformatf("%s end_txd", tag), 16'(txd), 16'd1);
        $display("frame %s done at clock %0d after load", tag, pos);
    endtask

    initial begin
        rst = 1'b1; baud_tick = 1'b1; wr = 1'b0; wr_data = 8'h00; fifo_clr = 1'b0;
        bc = 1'b0;
        set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset txd", 16'(txd), 16'd1);
        chk("reset thre", 16'(thre), 16'd1);
        chk("reset temt", 16'(temt), 16'd1);
        chk("reset level", 16'(level), 16'd0);
        adv(3);
        rst = 1'b0;
        adv(2);

        // 8N1 0x55: start 0, data 1,0,1,0,1,0,1,0
        write_byte(8'h55);
        chk("wr level", 16'(level), 16'd1);
        chk("wr thre", 16'(thre), 16'd0);
        chk("wr temt", 16'(temt), 16'd0);
        adv(1);
        pos = 0;
        chk("load txd", 16'(txd), 16'd0);
        chk("load thre", 16'(thre), 16'd1);
        chk("load temt", 16'(temt), 16'd0);
        chk("load level", 16'(level), 16'd0);
        check_frame("8N1_55", 16'h00AA, 0, 9, 16, 1'b1);

        // 7E1 0x41: data 1,0,0,0,0,0,1 parity 0
        set_lcr(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        launch(8'h41);
        check_frame("7E1_41", 16'h0082, 0, 9, 16, 1'b1);

        // 7O1 0x41: parity 1
        set_lcr(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        launch(8'h41);
        check_frame("7O1_41", 16'h0182, 0, 9, 16, 1'b1);

        // 8-bit stick parity, eps=0 -> parity bit constant 1
        set_lcr(2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        launch(8'h00);
        check_frame("8S1_00", 16'h0200, 0, 10, 16, 1'b1);

        // 5-bit, stb=1 0x1F -> 1.5 stop bits
        set_lcr(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        launch(8'h1F);
        check_frame("5N15_1F", 16'h003E, 0, 6, 24, 1'b1);

        // 8-bit, stb=1 0x1F -> 2 stop bits
        set_lcr(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        launch(8'h1F);
        check_frame("8N2_1F", 16'h003E, 0, 9, 32, 1'b1);

        // Break mid-frame over 0x0F (bits 1..4 are high)
        set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        launch(8'h0F);
        adv(24 - pos);
        bc = 1'b1;
        #1;
        chk("break on txd", 16'(txd), 16'd0);
        adv(50 - pos);
        chk("break hold txd", 16'(txd), 16'd0);
        adv(72 - pos);
        bc = 1'b0;
        #1;
        chk("break release bit4", 16'(txd), 16'd1);
        check_frame("brk_0F", 16'h001E, 5, 9, 16, 1'b1);

`ifdef UART_TX_FIFO_EN
        // Shifter held in its start bit while 17 bytes are offered
        baud_tick = 1'b0;
        launch(8'hFF);
        for (int i = 0; i < 17; i++) begin
            write_byte(8'(i));
        end
        chk("fifo full level", 16'(level), 16'd16);
        chk("fifo full thre", 16'(thre), 16'd0);
        baud_tick = 1'b1;
        pos = 0;
        check_frame("fifo_FF", 16'h01FE, 0, 9, 16, 1'b0);
        for (int i = 0; i < 16; i++) begin
            adv(1);
            pos = 0;
            check_frame($sformatf("fifo_%02h", i), {7'd0, 8'(i), 1'b0}, 0, 9, 16, (i == 15));
        end
        chk("fifo drained level", 16'(level), 16'd0);
`else
        // Second byte written during the start bit of the first
        launch(8'hAA);
        write_byte(8'hBB);
        chk("hold pending level", 16'(level), 16'd1);
        check_frame("hold_AA", 16'h0154, 0, 9, 16, 1'b0);
        adv(1);
        pos = 0;
        check_frame("hold_BB", 16'h0176, 0, 9, 16, 1'b1);

        // 0xCC overwrites 0xBB while 0x0F is on the line
        launch(8'h0F);
        adv(30 - pos);
        write_byte(8'hBB);
        adv(60 - pos);
        write_byte(8'hCC);
        chk("overwrite level", 16'(level), 16'd1);
        check_frame("ovr_0F", 16'h001E, 4, 9, 16, 1'b0);
        adv(1);
        pos = 0;
        check_frame("ovr_CC", 16'h0198, 0, 9, 16, 1'b1);
`endif

        // Clear with simultaneous write, then reset during a low bit of 0x5A
        launch(8'h5A);
        adv(10 - pos);
        write_byte(8'h77);
        chk("pre-clr level", 16'(level), 16'd1);
        wr = 1'b1; wr_data = 8'h66; fifo_clr = 1'b1;
        adv(1);
        wr = 1'b0; fifo_clr = 1'b0;
        chk("clr level", 16'(level), 16'd0);
        chk("clr thre", 16'(thre), 16'd1);
        adv(20 - pos);
        chk("pre-rst txd", 16'(txd), 16'd0);
        rst = 1'b1;
        #1;
        chk("rst txd", 16'(txd), 16'd1);
        chk("rst temt", 16'(temt), 16'd1);
        chk("rst level", 16'(level), 16'd0);
        rst = 1'b0;
        adv(20);
        chk("post-rst txd", 16'(txd), 16'd1);
        chk("post-rst temt", 16'(temt), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
